bus_cycle_sequencer: RTL
========================

Name: bus_cycle_sequencer

Overview:
Sequences one 6502-side bus access at a time through the chip-select decode regions. It generates one-hot chip selects, output/write strobes and a CPU ready line, with a per-region, runtime-configurable number of wait states. It sits between the CPU/bus-master request interface and the memory/peripheral chip selects of the chip-select project. All outputs are Moore, decoded from registered state.

Parameters:
ADDR_W, 16, address width
WAIT_W, 4, wait-state counter width (max 15 wait states)
RAM_WS_RST, 4'd0, reset wait states for the RAM region
IO_WS_RST, 4'd2, reset wait states for the IO region
ROM_WS_RST, 4'd1, reset wait states for the ROM region

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-high reset
req  in  1  access request; sampled only in IDLE
addr  in  ADDR_W  access address; sampled with req
rw  in  1  1 = read, 0 = write; sampled with req
cfg_we  in  1  wait-register write enable
cfg_sel  in  2  region select: 0 = RAM, 1 = IO, 2 = ROM, 3 = ignored
cfg_wdata  in  WAIT_W  new wait-state count
cs  out  3  one-hot chip select: bit0 RAM, bit1 IO, bit2 ROM
oe_n  out  1  active-low output enable (reads)
we_n  out  1  active-low write enable (writes)
rdy  out  1  CPU ready; low while an access is in flight
busy  out  1  high whenever state is not IDLE
ack  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse, coincident with ack, for unmapped accesses

Behaviour:
- Address decode (on addr at the sampling edge):
  - RAM: 0x0000–0x7FFF
  - IO: 0x8000–0x8FFF
  - ROM: 0xE000–0xFFFF
  - everything else is unmapped.
- Reset (asynchronous, any state):
  - state = IDLE
  - cs = 000, oe_n = 1, we_n = 1, rdy = 1, busy = 0, ack = 0, err = 0
  - wait registers reload the *_WS_RST values.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - Outputs idle; rdy = 1.
  - When req = 1: latch region, rw and counter = wait_reg[region] (unmapped: counter = 0); go to SETUP.
- SETUP (1 cycle):
  - cs = latched region, strobes high, rdy = 0, busy = 1.
  - Go to STROBE.
- STROBE (1+N cycles, N = latched wait count):
  - cs held; oe_n = 0 if read, we_n = 0 if write.
  - Counter decrements each cycle; when counter == 0, go to HOLD.
- HOLD (1 cycle):
  - Strobes high, cs held, ack = 1.
  - err = 1 if unmapped.
  - Go to IDLE.
- Latency: sampling edge = cycle 0; SETUP = cycle 1; STROBE = cycles 2..2+N; ack in cycle 3+N.
- Unmapped access:
  - cs = 000, no strobes, N = 0.
  - ack and err both in cycle 3.
- Ignored inputs: req, addr and rw outside IDLE are ignored, with no queueing. The requester holds or reissues after ack.
- Back-to-back: a req present in the first IDLE cycle after HOLD is accepted, so the minimum gap is one IDLE cycle.
- cs and strobes are never both asserted on different regions; only the latched region's cs is driven.
- Config writes:
  - cfg_we is accepted in any state.
  - cfg_sel = 3 is a no-op.
  - The update takes effect at the next edge and never alters an access already latched.
- Simultaneous cfg_we and req to the same region in IDLE: the access uses the old value; the new value applies from the next access.
- Reset asserted mid-access: outputs go idle immediately (asynchronously), with no ack and no err. After reset release the block is in IDLE with default waits.

Test Plan:
1. After reset, read at 0x1234 -> cs = 001 for cycles 1–3, oe_n low in cycle 2 only, we_n high, rdy low in cycles 1–3, ack in cycle 3, err = 0.
2. Write at 0x8010 (IO, N = 2) -> cs = 010, we_n low in cycles 2–4, oe_n high, ack in cycle 5.
3. cfg_we, cfg_sel = 2, cfg_wdata = 5, then read at 0xFFFC -> cs = 100, oe_n low in cycles 2–7, ack in cycle 8. Then cfg_sel = 3 with cfg_wdata = 9 -> the ROM read repeats with unchanged timing.
4. Read at 0xA000 (unmapped) -> cs = 000, oe_n and we_n stay high, ack and err both high in cycle 3.
5. IO write, assert rst during cycle 3 (STROBE) -> cs = 000, we_n = 1, rdy = 1, no ack. After release, RAM read at 0x0000 completes with ack in cycle 3.
6. cfg_we (sel 1, data 7) in the same cycle as an IO read request -> ack in cycle 5 (N = 2). A second IO read issued in the IDLE cycle after HOLD -> ack in cycle 10 of that access (N = 7). A req held throughout busy is not double-accepted.

Source files
------------

// File: rtl/bus_cycle_sequencer.sv
// Single-access 6502 bus sequencer: decodes the request into a chip-select region
// and walks SETUP / STROBE / HOLD with per-region, runtime-programmable wait states.
module bus_cycle_sequencer #(
  parameter int                ADDR_W     = 16,
  parameter int                WAIT_W     = 4,
  parameter logic [WAIT_W-1:0] RAM_WS_RST = 4'd0,
  parameter logic [WAIT_W-1:0] IO_WS_RST  = 4'd2,
  parameter logic [WAIT_W-1:0] ROM_WS_RST = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [WAIT_W-1:0] cfg_wdata,
  output logic [2:0]        cs,
  output logic              oe_n,
  output logic              we_n,
  output logic              rdy,
  output logic              busy,
  output logic              ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_ROM, REG_NONE} region_t;

  localparam logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(32'h8000);
  localparam logic [ADDR_W-1:0] IO_TOP   = ADDR_W'(32'h9000);
  localparam logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(32'hE000);

  state_t            state, state_nxt;
  region_t           region_q, region_dec;
  logic              rw_q;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic [WAIT_W-1:0] ws_ram, ws_io, ws_rom;
  logic [WAIT_W-1:0] ws_sel;
  logic              accept;

  assign accept = (state == IDLE) && req;

  always_comb begin
    region_dec = REG_NONE;
    if (addr < IO_BASE)                     region_dec = REG_RAM;
    else if (addr < IO_TOP)                 region_dec = REG_IO;
    else if (addr >= ROM_BASE)              region_dec = REG_ROM;
  end

  always_comb begin
    ws_sel = '0;
    case (region_dec)
      REG_RAM: ws_sel = ws_ram;
      REG_IO:  ws_sel = ws_io;
      REG_ROM: ws_sel = ws_rom;
      default: ws_sel = '0;
    endcase
  end

  // NOTE: the wait registers are a handful of flops, not a RAM, so they take the
  // async reset like any other state; a real memory array would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_ram <= RAM_WS_RST;
      ws_io  <= IO_WS_RST;
      ws_rom <= ROM_WS_RST;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    ws_ram <= cfg_wdata;
        2'd1:    ws_io  <= cfg_wdata;
        2'd2:    ws_rom <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      region_q <= REG_NONE;
      rw_q     <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        region_q <= region_dec;
        rw_q     <= rw;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SETUP;
          cnt_nxt   = ws_sel;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: begin
        if (cnt == '0) state_nxt = HOLD;
        else           cnt_nxt   = cnt - WAIT_W'(1);
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: decoded only from registered state and the latched access.
  always_comb begin
    cs   = 3'b000;
    oe_n = 1'b1;
    we_n = 1'b1;
    rdy  = 1'b1;
    busy = 1'b0;
    ack  = 1'b0;
    err  = 1'b0;
    if (state != IDLE) begin
      rdy  = 1'b0;
      busy = 1'b1;
      case (region_q)
        REG_RAM: cs = 3'b001;
        REG_IO:  cs = 3'b010;
        REG_ROM: cs = 3'b100;
        default: cs = 3'b000;
      endcase
    end
    if (state == STROBE && region_q != REG_NONE) begin
      oe_n = ~rw_q;
      we_n = rw_q;
    end
    if (state == HOLD) begin
      ack = 1'b1;
      err = (region_q == REG_NONE);
    end
  end

endmodule
